// File: rtl/multicycle_main_control.sv
// Main control FSM for the multicycle RV64I-subset datapath (R-type, ld, sd, beq).
// Drives ALUOp, datapath enables and mux selects; counts retired instructions.
module multicycle_main_control #(
   parameter int         CNT_W  = 16,
   parameter logic [6:0] OP_R   = 7'b0110011,
   parameter logic [6:0] OP_LD  = 7'b0000011,
   parameter logic [6:0] OP_SD  = 7'b0100011,
   parameter logic [6:0] OP_BEQ = 7'b1100011
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       Opcode,
   input  logic             mem_ready,
   output logic [1:0]       ALUOp,
   output logic             ALUSrcA,
   output logic [1:0]       ALUSrcB,
   output logic             PCSource,
   output logic             PCWrite,
   output logic             PCWriteCond,
   output logic             IorD,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             IRWrite,
   output logic             MemtoReg,
   output logic             RegWrite,
   output logic             illegal_op,
   output logic [CNT_W-1:0] retired,
   output logic [3:0]       state_dbg
);

   typedef enum logic [3:0] {
      S_FETCH     = 4'd0,
      S_DECODE    = 4'd1,
      S_MEM_ADDR  = 4'd2,
      S_MEM_READ  = 4'd3,
      S_MEM_WB    = 4'd4,
      S_MEM_WRITE = 4'd5,
      S_EXECUTE   = 4'd6,
      S_R_WB      = 4'd7,
      S_BRANCH    = 4'd8
   } state_t;

   state_t           state_reg;
   logic [CNT_W-1:0] retired_reg;
   logic             retire;

   // An instruction retires on the edge that leaves its final state.
   assign retire = (state_reg == S_MEM_WB) || (state_reg == S_R_WB) ||
                   (state_reg == S_BRANCH) ||
                   ((state_reg == S_MEM_WRITE) && mem_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= S_FETCH;
         retired_reg <= '0;
      end else begin
         if (retire)
            retired_reg <= retired_reg + CNT_W'(1);
         case (state_reg)
            S_FETCH:     if (mem_ready) state_reg <= S_DECODE;
            S_DECODE: begin
               if (Opcode == OP_LD || Opcode == OP_SD) state_reg <= S_MEM_ADDR;
               else if (Opcode == OP_R)                state_reg <= S_EXECUTE;
               else if (Opcode == OP_BEQ)              state_reg <= S_BRANCH;
               else                                    state_reg <= S_FETCH;
            end
            S_MEM_ADDR:  state_reg <= (Opcode == OP_SD) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  if (mem_ready) state_reg <= S_MEM_WB;
            S_MEM_WRITE: if (mem_ready) state_reg <= S_FETCH;
            S_EXECUTE:   state_reg <= S_R_WB;
            default:     state_reg <= S_FETCH;
         endcase
      end
   end

   // Outputs decode from the state register; rst_n low masks everything at once.
   always_comb begin
      ALUOp       = 2'b00;
      ALUSrcA     = 1'b0;
      ALUSrcB     = 2'b00;
      PCSource    = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 1'b0;
      RegWrite    = 1'b0;
      illegal_op  = 1'b0;
      if (rst_n) begin
         case (state_reg)
            S_FETCH: begin
               MemRead = 1'b1;
               ALUSrcB = 2'b01;
               IRWrite = mem_ready;
               PCWrite = mem_ready;
            end
            S_DECODE: begin
               ALUSrcB    = 2'b10;
               illegal_op = !(Opcode == OP_R || Opcode == OP_LD ||
                              Opcode == OP_SD || Opcode == OP_BEQ);
            end
            S_MEM_ADDR: begin
               ALUSrcA = 1'b1;
               ALUSrcB = 2'b10;
            end
            S_MEM_READ: begin
               MemRead = 1'b1;
               IorD    = 1'b1;
            end
            S_MEM_WB: begin
               RegWrite = 1'b1;
               MemtoReg = 1'b1;
            end
            S_MEM_WRITE: begin
               MemWrite = 1'b1;
               IorD     = 1'b1;
            end
            S_EXECUTE: begin
               ALUSrcA = 1'b1;
               ALUOp   = 2'b10;
            end
            S_R_WB:  RegWrite = 1'b1;
            S_BRANCH: begin
               ALUSrcA     = 1'b1;
               ALUOp       = 2'b01;
               PCWriteCond = 1'b1;
               PCSource    = 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign retired   = rst_n ? retired_reg : '0;
   assign state_dbg = rst_n ? state_reg : 4'd0;

endmodule

// File: doc/multicycle_main_control.md
Name: multicycle_main_control

Overview:
- Main control FSM for the multicycle RV64I-subset datapath. Supported instructions: R-type, ld, sd, beq.
- It produces the 2-bit ALUOp consumed by the ALU control decoder, plus every datapath enable and mux select.
- It sits between the instruction register (opcode field) and the datapath, and handshakes with the unified memory through mem_ready.
- It also keeps a retired-instruction counter and flags illegal opcodes.

Parameters:
- CNT_W, 16, width of the retired-instruction counter.
- OP_R, 7'b0110011, R-type opcode.
- OP_LD, 7'b0000011, load opcode.
- OP_SD, 7'b0100011, store opcode.
- OP_BEQ, 7'b1100011, branch opcode.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- Opcode  in  7  IR[6:0]; valid from DECODE onward
- mem_ready  in  1  memory has completed the current read/write this cycle
- ALUOp  out  2  00 add, 01 subtract, 10 funct-decoded
- ALUSrcA  out  1  0 = PC, 1 = register A
- ALUSrcB  out  2  00 = register B, 01 = constant 4, 10 = immediate
- PCSource  out  1  0 = ALU result, 1 = ALUOut
- PCWrite  out  1  unconditional PC write
- PCWriteCond  out  1  PC write qualified by ALU Zero
- IorD  out  1  0 = PC address, 1 = ALUOut address
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- MemtoReg  out  1  0 = ALUOut, 1 = MDR
- RegWrite  out  1  register file write
- illegal_op  out  1  one-cycle pulse on an unsupported opcode
- retired  out  CNT_W  instructions completed
- state_dbg  out  4  current state encoding

Behaviour:
- State encodings:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8.
  - Encodings 9-15 are unused and transition to FETCH.
- Reset:
  - While rst_n=0: state=FETCH, retired=0, and all outputs forced to 0. The forcing is combinational on rst_n.
  - Reset asserted mid-instruction abandons that instruction: no RegWrite, MemWrite or PC update occurs after rst_n falls.
- Output timing:
  - All control outputs are Moore: a function of state only, except the gating by mem_ready stated below.
  - Unlisted outputs are 0 in every state.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00.
  - IRWrite=mem_ready, PCWrite=mem_ready, PCSource=0.
  - Stays in FETCH until mem_ready=1, then goes to DECODE.
- DECODE:
  - ALUSrcA=0, ALUSrcB=10, ALUOp=00 (branch target into ALUOut).
  - Next state: OP_LD or OP_SD -> MEM_ADDR; OP_R -> EXECUTE; OP_BEQ -> BRANCH.
  - Any other opcode -> FETCH, with illegal_op pulsed for this one cycle and retired unchanged.
- MEM_ADDR:
  - ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - Next state: MEM_READ for ld, MEM_WRITE for sd. The opcode is re-sampled; IR is stable.
- MEM_READ:
  - MemRead=1, IorD=1.
  - Waits for mem_ready, then goes to MEM_WB.
- MEM_WB:
  - RegWrite=1, MemtoReg=1.
  - Goes to FETCH; retired increments.
- MEM_WRITE:
  - MemWrite=1, IorD=1.
  - Waits for mem_ready; on mem_ready goes to FETCH and retired increments.
- EXECUTE:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - Goes to R_WB.
- R_WB:
  - RegWrite=1, MemtoReg=0.
  - Goes to FETCH; retired increments.
- BRANCH:
  - ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=1.
  - Goes to FETCH; retired increments whether or not the branch is taken.
- Latency with mem_ready held at 1: ld 5 cycles, sd 4, R-type 4, beq 3, illegal opcode 2.
- Each cycle with mem_ready=0 in FETCH, MEM_READ or MEM_WRITE adds one cycle. In those cycles the request stays asserted and the write enables stay low.
- Counter: retired is CNT_W bits unsigned and wraps from all-ones to 0 without a flag.
- mem_ready is ignored in every state that does not issue a memory request.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles, then release with mem_ready=1 -> all outputs 0 during reset. On the first edge after release: state_dbg=0, MemRead=1, IRWrite=1, PCWrite=1.
- R-type: Opcode=0110011, mem_ready=1 -> state_dbg sequence 0,1,6,7,0. ALUOp=10 in state 6. RegWrite=1 only in state 7. retired goes 0->1.
- Load with stall: Opcode=0000011, mem_ready=0 for 2 cycles in MEM_READ -> states 0,1,2,3,3,3,4,0. MemRead/IorD held at 1 through the stall. RegWrite=1 with MemtoReg=1 in state 4.
- Store and branch:
  - sd -> MemWrite=1 only in state 5, and RegWrite never asserts.
  - beq -> states 0,1,8,0, with ALUOp=01 and PCWriteCond=1 in state 8.
  - retired advances by 2 across the pair.
- Illegal opcode: Opcode=1111111 -> states 0,1,0. illegal_op=1 for exactly one cycle, retired unchanged, no write enable asserted.
- Wrap and mid-instruction reset:
  - Preload the count to 16'hFFFF via a run of instructions (or force), then one R-type -> retired=0.
  - Pulse rst_n low while in MEM_WRITE -> MemWrite drops immediately and state is FETCH after release.
